// File: rtl/ice40_serdes_pkg.sv
// ice40_serdes_pkg
//   Shared definitions for the iCE40 SERDES receive-phase training controller:
//   default parameter values, FSM state encoding and the per-tap quality type.
package ice40_serdes_pkg;

  localparam int TAP_W_DEF      = 3;
  localparam int SETTLE_CYC_DEF = 16;
  localparam int DWELL_LOG2_DEF = 8;

  // FSM state encoding (plain constants so older tools and netlists map 1:1)
  typedef logic [3:0] state_t;
  localparam state_t ST_IDLE      = 4'd0;
  localparam state_t ST_WAIT_LOCK = 4'd1;
  localparam state_t ST_APPLY     = 4'd2;
  localparam state_t ST_SETTLE    = 4'd3;
  localparam state_t ST_DWELL     = 4'd4;
  localparam state_t ST_EVAL      = 4'd5;
  localparam state_t ST_FINISH    = 4'd6;
  localparam state_t ST_READY     = 4'd7;
  localparam state_t ST_FAIL      = 4'd8;

  // Verdict for one swept tap after its dwell window
  typedef enum logic [1:0] {
    TAP_GOOD    = 2'd0,
    TAP_NOVALID = 2'd1,
    TAP_ERROR   = 2'd2
  } tap_qual_e;

endpackage

// File: rtl/ice40_serdes_eye_track.sv
// ice40_serdes_eye_track
//   Run tracker for the tap sweep. Keeps the current run of good taps and the
//   widest run seen so far (earliest wins ties; no wrap from last tap to 0).
//   Ports:
//     clk_1x, rst_n     : clock, async active-low reset
//     i_clear           : drop all run state (new sweep / abort)
//     i_eval            : one tap verdict is presented this cycle
//     i_good            : verdict of that tap
//     i_tap             : index of that tap
//     o_best_len_nxt    : widest run length including this cycle's verdict
//     o_center_nxt      : floor centre of that run (meaningful when len >= 1)
module ice40_serdes_eye_track
  import ice40_serdes_pkg::*;
#(
  parameter int TAP_W = TAP_W_DEF
) (
  input  logic             clk_1x,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_eval,
  input  logic             i_good,
  input  logic [TAP_W-1:0] i_tap,
  output logic [TAP_W:0]   o_best_len_nxt,
  output logic [TAP_W-1:0] o_center_nxt
);

  logic [TAP_W-1:0] r_cur_start, r_best_start;
  logic [TAP_W:0]   r_cur_len,   r_best_len;

  logic [TAP_W-1:0] w_cur_start_n, w_best_start_n, w_run_start, w_len_m1;
  logic [TAP_W:0]   w_cur_len_n,   w_best_len_n,   w_run_len;

  always_comb begin
    w_run_len      = r_cur_len + 1'b1;
    w_run_start    = (r_cur_len == '0) ? i_tap : r_cur_start;
    w_cur_start_n  = r_cur_start;
    w_cur_len_n    = r_cur_len;
    w_best_start_n = r_best_start;
    w_best_len_n   = r_best_len;
    if (i_clear) begin
      w_cur_start_n  = '0;
      w_cur_len_n    = '0;
      w_best_start_n = '0;
      w_best_len_n   = '0;
    end else if (i_eval) begin
      if (i_good) begin
        w_cur_start_n = w_run_start;
        w_cur_len_n   = w_run_len;
        if (w_run_len > r_best_len) begin
          w_best_start_n = w_run_start;
          w_best_len_n   = w_run_len;
        end
      end else begin
        w_cur_len_n = '0;
      end
    end
  end

  always_ff @(posedge clk_1x or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_start  <= '0;
      r_cur_len    <= '0;
      r_best_start <= '0;
      r_best_len   <= '0;
    end else begin
      r_cur_start  <= w_cur_start_n;
      r_cur_len    <= w_cur_len_n;
      r_best_start <= w_best_start_n;
      r_best_len   <= w_best_len_n;
    end
  end

  // len-1 always fits TAP_W bits when len >= 1 (a full-width run of 2**TAP_W
  // has zero low bits and wraps to all ones, which is exactly len-1).
  assign w_len_m1       = w_best_len_n[TAP_W-1:0] - 1'b1;
  assign o_center_nxt   = w_best_start_n + (w_len_m1 >> 1);
  assign o_best_len_nxt = w_best_len_n;

endmodule

// File: rtl/ice40_serdes_train.sv
// ice40_serdes_train
//   Link bring-up and receive-phase training controller (clk_1x domain).
//   Sweeps every receive tap, scores each against the training pattern,
//   programs the centre of the widest contiguous good window and then holds
//   ready until lock is lost (automatic retrain) or start is pulsed.
//   Ports:
//     clk_1x, rst_n        : clock, async active-low reset
//     pll_lock             : raw PLL lock (synchronised internally, 2 FF)
//     start                : single-cycle (re)train request
//     rx_valid, rx_match   : per-word status from the datapath
//     tap_sel, tap_stb     : tap applied to the datapath, pulse on change
//     busy, ready, fail    : training status (fail sticky until next run)
//     done                 : one-cycle pulse at the end of a sweep
//     best_tap, eye_width  : chosen tap and width of the widest good run
module ice40_serdes_train
  import ice40_serdes_pkg::*;
#(
  parameter int TAP_W      = TAP_W_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int DWELL_LOG2 = DWELL_LOG2_DEF
) (
  input  logic             clk_1x,
  input  logic             rst_n,
  input  logic             pll_lock,
  input  logic             start,
  input  logic             rx_valid,
  input  logic             rx_match,
  output logic [TAP_W-1:0] tap_sel,
  output logic             tap_stb,
  output logic             busy,
  output logic             ready,
  output logic             fail,
  output logic             done,
  output logic [TAP_W-1:0] best_tap,
  output logic [TAP_W:0]   eye_width
);

  localparam int CNT_W = (DWELL_LOG2 > 8) ? DWELL_LOG2 : 8;
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] DWELL_LD  = CNT_W'((1 << DWELL_LOG2) - 1);
  localparam logic [TAP_W-1:0] LAST_TAP  = '1;

  logic             r_lock_s1, r_lock_s2;
  state_t           r_state;
  logic [TAP_W-1:0] r_tap;
  logic [CNT_W-1:0] r_cnt;
  logic             r_seen, r_err;
  logic [TAP_W-1:0] r_tap_sel, r_best_tap;
  logic [TAP_W:0]   r_eye_width;
  logic             r_tap_stb, r_busy, r_ready, r_fail, r_done;

  tap_qual_e        w_qual;
  logic             w_good, w_sweeping, w_abort, w_restart, w_clear, w_eval;
  logic [TAP_W:0]   w_best_len_nxt;
  logic [TAP_W-1:0] w_center_nxt;

  always_ff @(posedge clk_1x or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_s1 <= 1'b0;
      r_lock_s2 <= 1'b0;
    end else begin
      r_lock_s1 <= pll_lock;
      r_lock_s2 <= r_lock_s1;
    end
  end

  always_comb begin
    if (!r_seen)     w_qual = TAP_NOVALID;
    else if (r_err)  w_qual = TAP_ERROR;
    else             w_qual = TAP_GOOD;
  end
  assign w_good = (w_qual == TAP_GOOD);

  assign w_sweeping = (r_state == ST_APPLY) || (r_state == ST_SETTLE) ||
                      (r_state == ST_DWELL) || (r_state == ST_EVAL);
  assign w_abort    = w_sweeping && !r_lock_s2;
  // Entry into a fresh sweep: explicit request from a resting state, or lock
  // loss while trained.
  assign w_restart  = (start && ((r_state == ST_IDLE) || (r_state == ST_FAIL))) ||
                      ((r_state == ST_READY) && (start || !r_lock_s2));
  assign w_clear    = w_restart || w_abort;
  assign w_eval     = (r_state == ST_EVAL) && !w_abort;

  ice40_serdes_eye_track #(.TAP_W(TAP_W)) u_eye (
    .clk_1x         (clk_1x),
    .rst_n          (rst_n),
    .i_clear        (w_clear),
    .i_eval         (w_eval),
    .i_good         (w_good),
    .i_tap          (r_tap),
    .o_best_len_nxt (w_best_len_nxt),
    .o_center_nxt   (w_center_nxt)
  );

  // Outputs are registered on the edge that enters the state they belong to,
  // so tap_stb is visible during APPLY/FINISH and done during FINISH; ready
  // then rises one cycle later with READY.
  always_ff @(posedge clk_1x or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_tap       <= '0;
      r_cnt       <= '0;
      r_seen      <= 1'b0;
      r_err       <= 1'b0;
      r_tap_sel   <= '0;
      r_tap_stb   <= 1'b0;
      r_busy      <= 1'b0;
      r_ready     <= 1'b0;
      r_fail      <= 1'b0;
      r_done      <= 1'b0;
      r_best_tap  <= '0;
      r_eye_width <= '0;
    end else begin
      r_tap_stb <= 1'b0;
      r_done    <= 1'b0;
      if (w_abort) begin
        r_state <= ST_WAIT_LOCK;
        r_tap   <= '0;
      end else if (w_restart) begin
        r_state <= ST_WAIT_LOCK;
        r_tap   <= '0;
        r_busy  <= 1'b1;
        r_ready <= 1'b0;
        r_fail  <= 1'b0;
      end else begin
        case (r_state)
          ST_WAIT_LOCK: begin
            if (r_lock_s2) begin
              r_state   <= ST_APPLY;
              r_tap_sel <= r_tap;
              r_tap_stb <= 1'b1;
            end
          end
          ST_APPLY: begin
            r_state <= ST_SETTLE;
            r_cnt   <= SETTLE_LD;
          end
          ST_SETTLE: begin
            if (r_cnt == '0) begin
              r_state <= ST_DWELL;
              r_cnt   <= DWELL_LD;
              r_seen  <= 1'b0;
              r_err   <= 1'b0;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          ST_DWELL: begin
            r_seen <= r_seen | rx_valid;
            r_err  <= r_err | (rx_valid & ~rx_match);
            if (r_cnt == '0) r_state <= ST_EVAL;
            else             r_cnt   <= r_cnt - 1'b1;
          end
          ST_EVAL: begin
            r_tap_stb <= 1'b1;
            if (r_tap == LAST_TAP) begin
              r_state <= ST_FINISH;
              r_done  <= 1'b1;
              if (w_best_len_nxt != '0) begin
                r_best_tap  <= w_center_nxt;
                r_eye_width <= w_best_len_nxt;
                r_tap_sel   <= w_center_nxt;
              end else begin
                r_best_tap  <= '0;
                r_eye_width <= '0;
                r_tap_sel   <= '0;
                r_fail      <= 1'b1;
              end
            end else begin
              r_state   <= ST_APPLY;
              r_tap     <= r_tap + 1'b1;
              r_tap_sel <= r_tap + 1'b1;
            end
          end
          ST_FINISH: begin
            r_busy <= 1'b0;
            if (r_fail) begin
              r_state <= ST_FAIL;
            end else begin
              r_state <= ST_READY;
              r_ready <= 1'b1;
            end
          end
          ST_IDLE, ST_READY, ST_FAIL: ;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign tap_sel   = r_tap_sel;
  assign tap_stb   = r_tap_stb;
  assign busy      = r_busy;
  assign ready     = r_ready;
  assign fail      = r_fail;
  assign done      = r_done;
  assign best_tap  = r_best_tap;
  assign eye_width = r_eye_width;

endmodule

// File: tb/tb_ice40_serdes_train.sv
module tb_ice40_serdes_train;

  localparam int S = 4;
  localparam int D = 4;
  localparam int P = 2 + S + (1 << D);

  logic       clk_1x, rst_n, pll_lock, start, rx_valid, rx_match;
  logic [2:0] tap_sel, best_tap;
  logic [3:0] eye_width;
  logic       tap_stb, busy, ready, fail, done;

  // Per-tap behaviour of the simulated datapath: 0 clean, 1 mismatching, 2 silent
  logic [1:0] tap_mode [8];
  int n_tests = 0;
  int n_fail  = 0;

  ice40_serdes_train #(.TAP_W(3), .SETTLE_CYC(S), .DWELL_LOG2(D)) dut (
    .clk_1x    (clk_1x),
    .rst_n     (rst_n),
    .pll_lock  (pll_lock),
    .start     (start),
    .rx_valid  (rx_valid),
    .rx_match  (rx_match),
    .tap_sel   (tap_sel),
    .tap_stb   (tap_stb),
    .busy      (busy),
    .ready     (ready),
    .fail      (fail),
    .done      (done),
    .best_tap  (best_tap),
    .eye_width (eye_width)
  );

  initial begin
    clk_1x = 1'b0;
    forever #5 clk_1x = ~clk_1x;
  end

  // Datapath model: word status depends on the tap currently applied.
  initial begin
    rx_valid = 1'b0;
    rx_match = 1'b0;
    forever begin
      @(posedge clk_1x);
      #1;
      case (tap_mode[tap_sel])
        2'd0: begin
          rx_valid = ($urandom % 8) != 0;
          rx_match = rx_valid ? 1'b1 : 1'($urandom % 2);
        end
        2'd1: begin
          rx_valid = 1'b1;
          rx_match = ($urandom % 4) == 0;
        end
        default: begin
          rx_valid = 1'b0;
          rx_match = 1'($urandom % 2);
        end
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_modes(input logic [1:0] m0, m1, m2, m3, m4, m5, m6, m7);
    tap_mode[0] = m0; tap_mode[1] = m1; tap_mode[2] = m2; tap_mode[3] = m3;
    tap_mode[4] = m4; tap_mode[5] = m5; tap_mode[6] = m6; tap_mode[7] = m7;
  endtask

  // Widest all-clean span, by brute force over every (first,last) pair.
  task automatic ref_model(output int blen, output int bstart);
    bit ok;
    blen = 0;
    bstart = 0;
    for (int s = 0; s < 8; s++) begin
      for (int e = s; e < 8; e++) begin
        ok = 1'b1;
        for (int k = s; k <= e; k++) if (tap_mode[k] != 2'd0) ok = 1'b0;
        if (ok && (e - s + 1) > blen) begin
          blen = e - s + 1;
          bstart = s;
        end
      end
    end
  endtask

  task automatic train(input string tag, input bit do_start, input bit extra_start,
                       input bit lock_glitch);
    int blen, bstart, cyc, exp_idx, glitch_at, ndone;
    bit got, pass;
    logic [2:0] ecenter;
    ref_model(blen, bstart);
    pass = (blen > 0);
    ecenter = pass ? 3'(bstart + (blen - 1) / 2) : 3'd0;
    if (do_start) begin
      @(posedge clk_1x); #1 start = 1'b1;
      @(posedge clk_1x); #1 start = 1'b0;
    end
    cyc = 0; exp_idx = 0; got = 1'b0; glitch_at = -1;
    while (!got && cyc < 4000) begin
      @(negedge clk_1x);
      cyc++;
      if (cyc == 1) begin
        check({tag, "_busy_on"}, busy, 1);
        check({tag, "_ready_off"}, ready, 0);
        check({tag, "_fail_clr"}, fail, 0);
      end
      if (extra_start && cyc == 40) start = 1'b1;
      if (extra_start && cyc == 41) start = 1'b0;
      if (done) begin
        got = 1'b1;
      end else if (tap_stb) begin
        check({tag, "_stb_order"}, tap_sel, exp_idx);
        exp_idx++;
        if (lock_glitch && glitch_at < 0 && tap_sel == 3'd5) glitch_at = cyc + 1 + S + 5;
      end
      if (cyc == glitch_at) begin
        pll_lock = 1'b0;
        exp_idx = 0;
      end
      if (glitch_at > 0 && cyc == glitch_at + 4) pll_lock = 1'b1;
    end
    check({tag, "_done_seen"}, got, 1);
    if (do_start && !lock_glitch) check({tag, "_latency"}, cyc, 8 * P + 2);
    check({tag, "_n_stb"}, exp_idx, 8);
    check({tag, "_final_stb"}, tap_stb, 1);
    check({tag, "_tap_sel"}, tap_sel, ecenter);
    check({tag, "_best_tap"}, best_tap, ecenter);
    check({tag, "_eye_width"}, eye_width, blen);
    check({tag, "_fail"}, fail, !pass);
    check({tag, "_busy_fin"}, busy, 1);
    @(negedge clk_1x);
    check({tag, "_ready"}, ready, pass);
    check({tag, "_busy_off"}, busy, 0);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_stb_pulse"}, tap_stb, 0);
    ndone = 0;
    repeat (8) begin
      @(negedge clk_1x);
      if (done) ndone++;
    end
    check({tag, "_extra_done"}, ndone, 0);
    check({tag, "_hold_sel"}, tap_sel, ecenter);
  endtask

  initial begin
    int k;
    rst_n = 1'b0; start = 1'b0; pll_lock = 1'b0;
    set_modes(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk_1x);
    #1;
    check("rst_tap_sel", tap_sel, 0);
    check("rst_tap_stb", tap_stb, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", ready, 0);
    check("rst_fail", fail, 0);
    check("rst_done", done, 0);
    check("rst_best_tap", best_tap, 0);
    check("rst_eye_width", eye_width, 0);
    rst_n = 1'b1;
    pll_lock = 1'b1;
    repeat (4) @(posedge clk_1x);

    train("all_good", 1, 0, 0);
    set_modes(1, 2, 0, 0, 0, 0, 1, 1);
    train("win2_5", 1, 1, 0);
    set_modes(1, 0, 0, 1, 2, 0, 0, 1);
    train("tie", 1, 0, 0);
    set_modes(1, 2, 1, 1, 2, 1, 1, 0);
    train("only7", 1, 0, 0);
    set_modes(1, 1, 1, 1, 2, 1, 1, 1);
    train("no_good", 1, 0, 0);
    set_modes(1, 1, 1, 0, 0, 0, 0, 2);
    train("lock_glitch", 1, 0, 1);

    // Lock loss while trained: ready must fall quickly, then retrain by itself.
    @(negedge clk_1x);
    pll_lock = 1'b0;
    k = 0;
    while (ready && k < 6) begin
      @(negedge clk_1x);
      k++;
    end
    check("rdy_drop", ready, 0);
    check("rdy_drop_fast", (k <= 3), 1);
    check("rdy_drop_busy", busy, 1);
    set_modes(0, 0, 1, 0, 0, 0, 2, 0);
    repeat (3) @(negedge clk_1x);
    pll_lock = 1'b1;
    train("auto_retrain", 0, 0, 0);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 8; i++)
        tap_mode[i] = (($urandom % 3) == 0) ? ((($urandom % 2) == 0) ? 2'd1 : 2'd2) : 2'd0;
      train($sformatf("rand%0d", r), 1, 0, 0);
    end

    // Reset in the middle of a sweep takes effect without waiting for a clock.
    @(posedge clk_1x); #1 start = 1'b1;
    @(posedge clk_1x); #1 start = 1'b0;
    repeat (60) @(posedge clk_1x);
    #1;
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tap_sel", tap_sel, 0);
    check("mid_rst_tap_stb", tap_stb, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", ready, 0);
    check("mid_rst_fail", fail, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_best_tap", best_tap, 0);
    check("mid_rst_eye_width", eye_width, 0);
    @(posedge clk_1x); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk_1x);
    set_modes(2, 0, 0, 0, 1, 0, 0, 0);
    train("post_rst", 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ice40_serdes_train.md
# ice40_serdes_train

Link bring-up and receive-phase training controller for the iCE40 SERDES datapath, running in the `clk_1x` domain produced by the SERDES clock/reset generator.
- After PLL lock and on request, it sweeps every receive sampling tap, checks the recovered training pattern, and selects the centre of the widest contiguous good window.
- It programs that tap and holds `ready` until lock is lost or a retrain is requested.
- It owns the tap-select control of the datapath; the datapath supplies per-word match status.

## Interface
Parameters:
- `TAP_W`, 3: width of tap select; `2**TAP_W` taps swept.
- `SETTLE_CYC`, 16: cycles ignored after each tap change, range 1..255.
- `DWELL_LOG2`, 8: log2 of evaluation cycles per tap.

Ports:
- `clk_1x` in, 1: single clock; all logic posedge.
- `rst_n` in, 1: reset, asynchronous and active-low.
- `pll_lock` in, 1: PLL lock, synchronised inside with a 2-FF synchroniser.
- `start` in, 1: single-cycle request to (re)train.
- `rx_valid` in, 1: datapath produced a word this cycle.
- `rx_match` in, 1: that word equals the training pattern; qualified by `rx_valid`.
- `tap_sel` out, TAP_W: tap applied to the datapath.
- `tap_stb` out, 1: one-cycle pulse, asserted in the cycle `tap_sel` takes a new value.
- `busy` out, 1: training in progress.
- `ready` out, 1: trained and locked.
- `fail` out, 1: last training found no good tap; sticky until the next training starts.
- `done` out, 1: one-cycle pulse at the end of training, pass or fail.
- `best_tap` out, TAP_W: selected tap.
- `eye_width` out, TAP_W+1: length of the widest good run.

## Operation
- FSM states: IDLE, WAIT_LOCK, APPLY, SETTLE, DWELL, EVAL, FINISH, READY, FAIL.
- IDLE/READY/FAIL + `start` -> WAIT_LOCK.
  - On entry: `busy`=1, `ready`=0, `fail`=0.
  - Run trackers cleared; tap counter = 0.
  - `start` in any other state is ignored.
- WAIT_LOCK: stay until synchronised lock = 1, then go to APPLY.
- APPLY, 1 cycle: `tap_sel`<=tap counter, `tap_stb`=1 -> SETTLE.
- SETTLE: exactly `SETTLE_CYC` cycles; inputs ignored -> DWELL.
- DWELL: exactly `2**DWELL_LOG2` cycles.
  - Count cycles with `rx_valid`=1.
  - Set an error flag on any cycle with `rx_valid`=1 and `rx_match`=0.
- EVAL, 1 cycle. A tap is good iff valid count ≥ 1 and the error flag is 0.
  - Good tap: if `cur_len`==0 then `cur_start`<=tap; `cur_len`<=`cur_len`+1. If `cur_len`+1 > `best_len` (strictly greater, so the earliest run wins ties), update `best_start`/`best_len`.
  - Bad tap: `cur_len`<=0.
  - Not the last tap: increment tap -> APPLY. Last tap -> FINISH.
  - Runs do not wrap from the last tap to tap 0.
- FINISH, 1 cycle.
  - `best_len`≥1:
    - `best_tap`<=`best_start`+((`best_len`-1)>>1), floor of the centre.
    - `eye_width`<=`best_len`; `tap_sel`<=`best_tap`; `tap_stb`=1; `done`=1.
    - Next state READY.
  - `best_len`=0:
    - `tap_sel`<=0; `tap_stb`=1; `best_tap`<=0; `eye_width`<=0.
    - `fail`<=1; `done`=1.
    - Next state FAIL.
- Leaving FINISH always sets `busy`<=0.
- READY: `ready`=1. Synchronised lock falling -> `ready`<=0, `busy`<=1, automatic retrain via WAIT_LOCK.
- Lock loss during APPLY..EVAL: abort, go to WAIT_LOCK, clear trackers, restart from tap 0. No `done` pulse.
- Lock loss in IDLE or FAIL: no action.
- Arithmetic: `cur_len`/`best_len` are TAP_W+1 bits, max `2**TAP_W`, no overflow. Tap counter is TAP_W bits; last tap = all ones.

## Timing
- Reset values: `tap_sel`=0, `tap_stb`=0, `busy`=0, `ready`=0, `fail`=0, `done`=0, `best_tap`=0, `eye_width`=0; state IDLE.
- `start` at cycle n -> `busy`=1 at n+1.
- Pattern lock-latency: 2 cycles from `pll_lock` to internal lock.
- Per tap: 1 (APPLY) + `SETTLE_CYC` + `2**DWELL_LOG2` + 1 (EVAL) cycles.
- Total with lock already stable: 1 + `2**TAP_W`·(2+`SETTLE_CYC`+`2**DWELL_LOG2`) + 1 cycles to the `done` pulse.
- `ready` rises in the cycle after `done`, coincident with READY.
- All outputs are registered.

## Structure
- Package `ice40_serdes_pkg`: FSM state enum, tap-quality typedef, default parameter constants.
- One sub-module: `ice40_serdes_eye_track` holds the run tracker (cur/best start and length, centre computation).
- The FSM and counters stay in the top.

## Test plan
- TAP_W=3, all taps matching -> `eye_width`=8, `best_tap`=3, `ready`=1, `fail`=0, exactly one `done` pulse.
- Good taps 2..5 only -> `eye_width`=4, `best_tap`=3, final `tap_sel`=3 with a `tap_stb` pulse.
- Tied runs {1,2} and {5,6} -> `best_tap`=1, `eye_width`=2; a single good tap 7 alone -> `best_tap`=7.
- No good taps (`rx_valid` never 1 on tap 4, mismatches elsewhere) -> `fail`=1, `tap_sel`=0, `ready`=0, `eye_width`=0.
- `pll_lock` dropped mid-DWELL of tap 5 and restored -> no `done`; sweep restarts with `tap_sel`=0 and completes correctly.
- `start` pulsed while busy -> ignored. In READY, lock drop -> `ready`=0 within 3 cycles, then automatic retrain. `rst_n` asserted mid-sweep -> all outputs at reset values immediately.
